// File: rtl/serial_rx_ext.sv
// serial_rx_ext - parametrised UART receiver with one-word output buffer.
//
// Receives asynchronous serial frames (start, DATA_BITS data LSB first,
// optional parity, STOP_BITS stop) from a raw pad, votes each bit over three
// synchronised samples and presents the word through a valid/ready buffer.
//
// Optional feature: define SERIAL_RX_PARITY_EN to expect and check a parity
// bit after the data bits (ODD_PARITY selects odd/even). Without the macro
// no parity bit is expected and o_perr is constant 0.
//
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_rx              serial line, idle high, asynchronous to i_clk
//   o_valid / i_ready buffered-word handshake
//   o_data            received word, right-justified
//   o_ferr / o_perr   framing / parity error of the buffered word
//   o_ovr             sticky: a word was dropped because the buffer was full
//   o_brk             one-cycle pulse when a break frame is seen
module serial_rx_ext #(
  parameter int CLK_FREQ   = 48_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int ODD_PARITY = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_ferr,
  output logic                 o_perr,
  output logic                 o_ovr,
  output logic                 o_brk
);

  localparam int              BAUD_CLKS = CLK_FREQ / BAUD_RATE;
  localparam int              TW        = $clog2(BAUD_CLKS);
  localparam logic [TW-1:0]   HALF      = TW'(BAUD_CLKS >> 1);
  localparam logic [TW-1:0]   FULL      = TW'(BAUD_CLKS - 1);
  localparam logic [3:0]      LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]      LAST_STOP = 4'(STOP_BITS - 1);
  localparam bit              ODD       = (ODD_PARITY != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q;
  logic [2:0]           hist_q;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic [3:0]           cnt_q, cnt_d;       // data bit index, reused for stop bits
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 ferr_q, ferr_d;
  logic                 zero_q, zero_d;     // every break-relevant sample so far was 0
  logic                 perr_q, perr_d;
  logic                 buf_perr;
  logic                 v, tick, done;

  // Majority of the last three synchronised samples rejects 1-cycle spikes.
  assign v    = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
  assign tick = (tmr_q == '0);

  always_comb begin
    state_d = state_q;
    tmr_d   = tick ? tmr_q : tmr_q - 1'b1;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ferr_d  = ferr_q;
    zero_d  = zero_q;
    perr_d  = perr_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        // Raw synchronised level, so a start edge is seen immediately.
        if (!sync_q[1]) begin
          tmr_d   = HALF;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if (v) begin
            state_d = IDLE;
          end else begin
            tmr_d   = FULL;
            cnt_d   = '0;
            ferr_d  = 1'b0;
            perr_d  = 1'b0;
            zero_d  = 1'b1;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (tick) begin
          sh_d   = {v, sh_q[DATA_BITS-1:1]};
          zero_d = zero_q & ~v;
          tmr_d  = FULL;
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == LAST_DATA) begin
            cnt_d = '0;
`ifdef SERIAL_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          // XOR over data and parity bit must equal 1 for odd, 0 for even.
          perr_d  = ((^sh_q) ^ v) != ODD;
          zero_d  = zero_q & ~v;
          tmr_d   = FULL;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (!v) ferr_d = 1'b1;
          // Only the first stop sample counts towards break detection.
          if (cnt_q == '0) zero_d = zero_q & ~v;
          tmr_d = FULL;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LAST_STOP) begin
            done    = 1'b1;
            state_d = v ? IDLE : WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (v) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q  <= 2'b11;
      hist_q  <= 3'b111;
      state_q <= IDLE;
      tmr_q   <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      ferr_q  <= 1'b0;
      zero_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], i_rx};
      hist_q  <= {hist_q[1:0], sync_q[1]};
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ferr_q  <= ferr_d;
      zero_q  <= zero_d;
      perr_q  <= perr_d;
    end
  end

  // Output buffer. A load in the same cycle as an accept wins over the clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_ferr   <= 1'b0;
      buf_perr <= 1'b0;
      o_ovr    <= 1'b0;
      o_brk    <= 1'b0;
    end else begin
      o_brk <= 1'b0;
      if (o_valid && i_ready) begin
        o_valid <= 1'b0;
        o_ovr   <= 1'b0;
      end
      if (done) begin
        if (zero_d) begin
          o_brk <= 1'b1;
        end else if (!o_valid || i_ready) begin
          o_valid  <= 1'b1;
          o_data   <= sh_q;
          o_ferr   <= ferr_d;
          buf_perr <= perr_q;
        end else begin
          o_ovr <= 1'b1;
        end
      end
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  assign o_perr = buf_perr;
`else
  // Parity not compiled in: perr_q never sets and ODD_PARITY has no effect.
  assign o_perr = buf_perr & ODD & 1'b0;
`endif

endmodule

// File: tb/tb_serial_rx_ext.sv
// Directed bench for serial_rx_ext: default-parameter instance (BAUD_CLKS=416)
// plus a DATA_BITS=5 / STOP_BITS=2 / BAUD_CLKS=16 instance.
module tb_serial_rx_ext;
  localparam int BA = 416;
  localparam int BB = 16;
`ifdef SERIAL_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NA = 10 + PB;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       rx_a = 1'b1, rx_b = 1'b1, rdy_a = 1'b1, rdy_b = 1'b1;
  logic       a_valid, a_ferr, a_perr, a_ovr, a_brk;
  logic [7:0] a_data;
  logic       b_valid, b_ferr, b_perr, b_ovr, b_brk;
  logic [4:0] b_data;

  int n_chk = 0, n_fail = 0;
  int vcnt_a = 0, brk_a = 0, vcnt_b = 0;
  logic       pv_a = 1'b0, pv_b = 1'b0;
  logic [7:0] cap_a = '0;
  logic       cap_ferr_a = 1'b0, cap_perr_a = 1'b0;
  logic [4:0] cap_b = '0;
  logic       cap_ferr_b = 1'b0;

  always #5 i_clk = ~i_clk;

  serial_rx_ext dut_a (
    .i_clk(i_clk), .i_rst(i_rst), .i_rx(rx_a), .o_valid(a_valid), .i_ready(rdy_a),
    .o_data(a_data), .o_ferr(a_ferr), .o_perr(a_perr), .o_ovr(a_ovr), .o_brk(a_brk)
  );

  serial_rx_ext #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(5), .STOP_BITS(2)) dut_b (
    .i_clk(i_clk), .i_rst(i_rst), .i_rx(rx_b), .o_valid(b_valid), .i_ready(rdy_b),
    .o_data(b_data), .o_ferr(b_ferr), .o_perr(b_perr), .o_ovr(b_ovr), .o_brk(b_brk)
  );

  // Capture each newly buffered word and count break pulses.
  always @(negedge i_clk) begin
    if (a_valid && !pv_a) begin
      vcnt_a++; cap_a = a_data; cap_ferr_a = a_ferr; cap_perr_a = a_perr;
    end
    pv_a = a_valid;
    if (a_brk) brk_a++;
    if (b_valid && !pv_b) begin
      vcnt_b++; cap_b = b_data; cap_ferr_b = b_ferr;
    end
    pv_b = b_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  // Drive n bits (LSB first) of baud cycles each; invert the line for one
  // cycle at index glitch; stop early after maxc cycles. Line left high.
  task automatic send(input bit sel, input logic [31:0] bits, input int n, input int baud,
                      input int glitch, input int maxc);
    int c;
    logic x;
    c = 0;
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < baud; k++) begin
        if (c < maxc) begin
          x = bits[b] ^ (c == glitch);
          if (sel) rx_b = x; else rx_a = x;
          @(posedge i_clk); #1;
        end
        c++;
      end
    end
    if (sel) rx_b = 1'b1; else rx_a = 1'b1;
  endtask

  // Frame for dut_a: start, 8 data bits, even parity (optionally flipped) when built in, stop.
  function automatic logic [31:0] fa(input logic [7:0] d, input logic stop, input logic pflip);
    logic [31:0] b;
    b = '0;
    b[8:1] = d;
    if (PB != 0) begin b[9] = (^d) ^ pflip; b[10] = stop; end
    else b[9] = stop;
    return b;
  endfunction

  task automatic frame_a(input logic [7:0] d, input logic stop, input logic pflip,
                         input int glitch, input int maxc);
    send(1'b0, fa(d, stop, pflip), NA, BA, glitch, maxc);
  endtask

  initial begin
    idle(3);
    chk("rst_valid", a_valid, 0);
    chk("rst_data", a_data, 0);
    chk("rst_ferr", a_ferr, 0);
    chk("rst_perr", a_perr, 0);
    chk("rst_ovr", a_ovr, 0);
    chk("rst_brk", a_brk, 0);
    i_rst = 1'b0;
    idle(10);

    // Basic receive
    frame_a(8'h55, 1'b1, 1'b0, -1, 1 << 30);
    idle(5);
    chk("b55_cnt", vcnt_a, 1);
    chk("b55_data", cap_a, 8'h55);
    chk("b55_ferr", cap_ferr_a, 0);
    chk("b55_perr", cap_perr_a, 0);
    chk("b55_ovr", a_ovr, 0);
    frame_a(8'hA3, 1'b1, 1'b0, -1, 1 << 30);
    idle(5);
    chk("bA3_cnt", vcnt_a, 2);
    chk("bA3_data", cap_a, 8'hA3);
    chk("bA3_ferr", cap_ferr_a, 0);

    // Short glitch on idle line
    send(1'b0, 32'h0, 1, 100, -1, 1 << 30);
    idle(600);
    chk("glitch_cnt", vcnt_a, 2);
    chk("glitch_brk", brk_a, 0);

    // Overrun
    rdy_a = 1'b0;
    frame_a(8'h11, 1'b1, 1'b0, -1, 1 << 30);
    idle(5);
    chk("ovr_first_ovr", a_ovr, 0);
    frame_a(8'h22, 1'b1, 1'b0, -1, 1 << 30);
    idle(5);
    chk("ovr_cnt", vcnt_a, 3);
    chk("ovr_valid", a_valid, 1);
    chk("ovr_data", a_data, 8'h11);
    chk("ovr_flag", a_ovr, 1);
    rdy_a = 1'b1;
    idle(1);
    rdy_a = 1'b0;
    chk("accept_valid", a_valid, 0);
    chk("accept_ovr", a_ovr, 0);
    rdy_a = 1'b1;
    idle(10);

    // Framing error, then break
    frame_a(8'h3C, 1'b0, 1'b0, -1, 1 << 30);
    idle(50);
    chk("ferr_cnt", vcnt_a, 4);
    chk("ferr_data", cap_a, 8'h3C);
    chk("ferr_flag", cap_ferr_a, 1);
    send(1'b0, 32'h0, 1, 20 * BA, -1, 1 << 30);
    idle(200);
    chk("brk_cnt", brk_a, 1);
    chk("brk_novalid", vcnt_a, 4);
    frame_a(8'h7E, 1'b1, 1'b0, -1, 1 << 30);
    idle(5);
    chk("b7E_cnt", vcnt_a, 5);
    chk("b7E_data", cap_a, 8'h7E);
    chk("b7E_ferr", cap_ferr_a, 0);

`ifdef SERIAL_RX_PARITY_EN
    frame_a(8'h07, 1'b1, 1'b0, -1, 1 << 30);
    idle(5);
    chk("par_ok_data", cap_a, 8'h07);
    chk("par_ok_perr", cap_perr_a, 0);
    frame_a(8'h07, 1'b1, 1'b1, -1, 1 << 30);
    idle(5);
    chk("par_bad_perr", cap_perr_a, 1);
    chk("par_cnt", vcnt_a, 7);
`endif

    // One-cycle 1 spike at the centre of data bit 0 (a 0)
    rdy_a = 1'b0;
    frame_a(8'hF0, 1'b1, 1'b0, BA + BA / 2, 1 << 30);
    idle(5);
    chk("noise_data", cap_a, 8'hF0);
    chk("noise_valid", a_valid, 1);

    // Reset mid-frame
    frame_a(8'hC5, 1'b1, 1'b0, -1, 2000);
    i_rst = 1'b1;
    #1;
    chk("mrst_valid", a_valid, 0);
    chk("mrst_data", a_data, 0);
    chk("mrst_ovr", a_ovr, 0);
    idle(5);
    i_rst = 1'b0;
    rdy_a = 1'b1;
    idle(4500);
    chk("mrst_noword", a_valid, 0);
    chk("mrst_ferr", a_ferr, 0);
    frame_a(8'hC5, 1'b1, 1'b0, -1, 1 << 30);
    idle(5);
    chk("bC5_data", cap_a, 8'hC5);
    chk("bC5_ferr", cap_ferr_a, 0);

    // 5 data bits, 2 stop bits, 16 clocks per bit
    send(1'b1, {24'h0, 2'b11, 5'h1B, 1'b0}, 8, BB, -1, 1 << 30);
    idle(5);
    chk("g_cnt", vcnt_b, 1);
    chk("g_data", cap_b, 5'h1B);
    chk("g_ferr", cap_ferr_b, 0);
    send(1'b1, {24'h0, 2'b01, 5'h0A, 1'b0}, 8, BB, -1, 1 << 30);
    idle(20);
    chk("g2_cnt", vcnt_b, 2);
    chk("g2_data", cap_b, 5'h0A);
    chk("g2_ferr", cap_ferr_b, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
